// File: rtl/chien_search_par.sv
// Lane-parallel Chien search: evaluates one or two error-locator polynomials per job
// over GF(2^6/2^8/2^10) and reports error positions with ready/valid handshakes.
module chien_search_par #(
  parameter int unsigned PAR   = 8,
  parameter int unsigned T_MAX = 4,
  parameter int unsigned M     = 10
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [1:0]             i_code,
  input  logic                   i_mode,
  input  logic [(T_MAX+1)*M-1:0] i_sigma_a,
  input  logic [(T_MAX+1)*M-1:0] i_sigma_b,
  output logic                   o_ready,
  output logic                   o_valid,
  input  logic                   i_out_ready,
  output logic [T_MAX*M-1:0]     o_err_loc,
  output logic [2:0]             o_num_err,
  output logic                   o_correct,
  output logic                   o_last
);

  localparam int unsigned CW    = (T_MAX + 1) * M;
  localparam int unsigned LW    = T_MAX * M;
  localparam int unsigned POS_W = 11;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, OUT} state_t;

  // Multiply by alpha (= x) in the field selected by code.
  function automatic logic [M-1:0] xtime(input logic [M-1:0] x, input logic [1:0] c);
    logic [M-1:0] s, red, msk;
    logic         top;
    s = {x[M-2:0], 1'b0};
    case (c)
      2'b00:   begin top = x[5]; red = M'(10'h003); msk = M'(10'h03F); end
      2'b01:   begin top = x[7]; red = M'(10'h01D); msk = M'(10'h0FF); end
      default: begin top = x[9]; red = M'(10'h009); msk = M'(10'h3FF); end
    endcase
    s = s & msk;
    if (top) s = s ^ red;
    return s;
  endfunction

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b,
                                          input logic [1:0] c);
    logic [M-1:0] p;
    p = '0;
    for (int i = int'(M) - 1; i >= 0; i--) begin
      p = xtime(p, c);
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

  function automatic logic [M-1:0] alpha_pow(input int unsigned e, input logic [1:0] c);
    logic [M-1:0] x;
    x = M'(1);
    for (int unsigned j = 0; j < e; j++) x = xtime(x, c);
    return x;
  endfunction

  state_t            state, state_nxt;
  logic [1:0]        code_q, code_nxt;
  logic              two_q, two_nxt, cand_q, cand_nxt;
  logic [CW-1:0]     sig_a_q, sig_a_nxt, sig_b_q, sig_b_nxt;
  logic [M-1:0]      c0_q, c0_nxt;
  logic [M-1:0]      r_q [T_MAX];
  logic [M-1:0]      r_nxt [T_MAX];
  logic [M-1:0]      slot_q [T_MAX];
  logic [M-1:0]      slot_nxt [T_MAX];
  logic [CNT_W-1:0]  deg_q, deg_nxt, roots_q, roots_nxt, cnt, t_code;
  logic [POS_W-1:0]  pos_q, pos_nxt, pos_init;
  logic              ovf_q, ovf_nxt, emit, last_cand;
  logic [M-1:0]      msk, sum, co;
  logic [CW-1:0]     sel;
  logic [LW-1:0]     err_loc_nxt;
  logic [2:0]        num_err_nxt;
  logic              correct_nxt, last_nxt;
  logic [M-1:0]      step [T_MAX];
  logic [M-1:0]      lane_k [T_MAX][PAR];

  // Per-field constants: per-cycle advance alpha^(PAR*k) and lane offsets alpha^((l+1)*k).
  for (genvar k = 0; k < T_MAX; k++) begin : g_step
    localparam logic [M-1:0] S0 = alpha_pow((k + 1) * PAR, 2'b00);
    localparam logic [M-1:0] S1 = alpha_pow((k + 1) * PAR, 2'b01);
    localparam logic [M-1:0] S2 = alpha_pow((k + 1) * PAR, 2'b10);
    assign step[k] = (code_q == 2'b00) ? S0 : (code_q == 2'b01) ? S1 : S2;
    for (genvar l = 0; l < PAR; l++) begin : g_lane
      localparam logic [M-1:0] L0 = alpha_pow((k + 1) * (l + 1), 2'b00);
      localparam logic [M-1:0] L1 = alpha_pow((k + 1) * (l + 1), 2'b01);
      localparam logic [M-1:0] L2 = alpha_pow((k + 1) * (l + 1), 2'b10);
      assign lane_k[k][l] = (code_q == 2'b00) ? L0 : (code_q == 2'b01) ? L1 : L2;
    end
  end

  always_comb begin
    case (code_q)
      2'b00:   begin msk = M'(10'h03F); t_code = CNT_W'(2); pos_init = POS_W'(62);   end
      2'b01:   begin msk = M'(10'h0FF); t_code = CNT_W'(2); pos_init = POS_W'(254);  end
      default: begin msk = M'(10'h3FF); t_code = CNT_W'(4); pos_init = POS_W'(1022); end
    endcase
  end

  assign last_cand = cand_q | ~two_q;
  assign sel       = cand_q ? sig_b_q : sig_a_q;

  always_comb begin
    state_nxt   = state;
    code_nxt    = code_q;
    two_nxt     = two_q;
    cand_nxt    = cand_q;
    sig_a_nxt   = sig_a_q;
    sig_b_nxt   = sig_b_q;
    c0_nxt      = c0_q;
    deg_nxt     = deg_q;
    roots_nxt   = roots_q;
    pos_nxt     = pos_q;
    ovf_nxt     = ovf_q;
    for (int k = 0; k < int'(T_MAX); k++) begin
      r_nxt[k]    = r_q[k];
      slot_nxt[k] = slot_q[k];
    end
    err_loc_nxt = o_err_loc;
    num_err_nxt = o_num_err;
    correct_nxt = o_correct;
    last_nxt    = o_last;
    emit        = 1'b0;
    cnt         = roots_q;
    sum         = '0;
    co          = '0;

    case (state)
      IDLE: if (i_start) begin
        code_nxt  = i_code;
        two_nxt   = i_mode & ~i_code[1];
        cand_nxt  = 1'b0;
        sig_a_nxt = i_sigma_a;
        sig_b_nxt = i_sigma_b;
        state_nxt = LOAD;
      end
      LOAD: begin
        c0_nxt  = sel[M-1:0] & msk;
        deg_nxt = '0;
        for (int k = 0; k < int'(T_MAX); k++) begin
          co = sel[(k+1)*M +: M] & msk;
          if (CNT_W'(k + 1) > t_code) co = '0;
          r_nxt[k]    = co;
          slot_nxt[k] = '0;
          if (co != '0) deg_nxt = CNT_W'(k + 1);
        end
        pos_nxt   = pos_init;
        roots_nxt = '0;
        ovf_nxt   = 1'b0;
        if (code_q == 2'b11 || deg_nxt == '0) begin
          state_nxt = OUT;
          emit      = 1'b1;
        end else begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        // Lane l tests position pos_q - l; roots land in slots in lane order.
        for (int l = 0; l < int'(PAR); l++) begin
          if (POS_W'(l) <= pos_q) begin
            sum = c0_q;
            for (int k = 0; k < int'(T_MAX); k++) sum = sum ^ gf_mul(r_q[k], lane_k[k][l], code_q);
            if (sum == '0) begin
              if (cnt < t_code) begin
                for (int s = 0; s < int'(T_MAX); s++)
                  if (CNT_W'(s) == cnt) slot_nxt[s] = M'(pos_q - POS_W'(l));
                cnt = cnt + CNT_W'(1);
              end else begin
                ovf_nxt = 1'b1;
              end
            end
          end
        end
        for (int k = 0; k < int'(T_MAX); k++) r_nxt[k] = gf_mul(r_q[k], step[k], code_q);
        roots_nxt = cnt;
        pos_nxt   = pos_q - POS_W'(PAR);
        if (cnt == deg_q || pos_q < POS_W'(PAR)) begin
          state_nxt = OUT;
          emit      = 1'b1;
        end
      end
      OUT: if (i_out_ready) begin
        if (last_cand) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = LOAD;
          cand_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (emit) begin
      for (int s = 0; s < int'(T_MAX); s++) err_loc_nxt[s*M +: M] = slot_nxt[s];
      num_err_nxt = roots_nxt;
      correct_nxt = (code_q != 2'b11) && (c0_nxt != '0) && !ovf_nxt && (roots_nxt == deg_nxt);
      last_nxt    = last_cand;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      code_q    <= '0;
      two_q     <= 1'b0;
      cand_q    <= 1'b0;
      sig_a_q   <= '0;
      sig_b_q   <= '0;
      c0_q      <= '0;
      deg_q     <= '0;
      roots_q   <= '0;
      pos_q     <= '0;
      ovf_q     <= 1'b0;
      for (int k = 0; k < int'(T_MAX); k++) begin
        r_q[k]    <= '0;
        slot_q[k] <= '0;
      end
      o_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o_err_loc <= '0;
      o_num_err <= '0;
      o_correct <= 1'b0;
      o_last    <= 1'b0;
    end else begin
      state     <= state_nxt;
      code_q    <= code_nxt;
      two_q     <= two_nxt;
      cand_q    <= cand_nxt;
      sig_a_q   <= sig_a_nxt;
      sig_b_q   <= sig_b_nxt;
      c0_q      <= c0_nxt;
      deg_q     <= deg_nxt;
      roots_q   <= roots_nxt;
      pos_q     <= pos_nxt;
      ovf_q     <= ovf_nxt;
      for (int k = 0; k < int'(T_MAX); k++) begin
        r_q[k]    <= r_nxt[k];
        slot_q[k] <= slot_nxt[k];
      end
      o_ready   <= (state_nxt == IDLE);
      o_valid   <= (state_nxt == OUT);
      o_err_loc <= err_loc_nxt;
      o_num_err <= num_err_nxt;
      o_correct <= correct_nxt;
      o_last    <= last_nxt;
    end
  end

endmodule

// File: tb/tb_chien_search_par.sv
// Directed bench for chien_search_par: table of single-result jobs plus hand sequences
// for two-candidate jobs, output back-pressure and reset during a scan.
module tb_chien_search_par;

  localparam int unsigned PAR   = 8;
  localparam int unsigned T_MAX = 4;
  localparam int unsigned M     = 10;
  localparam int unsigned CW    = (T_MAX + 1) * M;
  localparam int unsigned LW    = T_MAX * M;

  logic          clk, rst_n, start, mode, valid, ready, out_ready, correct, last;
  logic [1:0]    code;
  logic [CW-1:0] sigma_a, sigma_b;
  logic [LW-1:0] err_loc;
  logic [2:0]    num_err;

  int checks = 0;
  int errors = 0;

  chien_search_par #(.PAR(PAR), .T_MAX(T_MAX), .M(M)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_code(code), .i_mode(mode),
    .i_sigma_a(sigma_a), .i_sigma_b(sigma_b), .o_ready(ready), .o_valid(valid),
    .i_out_ready(out_ready), .o_err_loc(err_loc), .o_num_err(num_err),
    .o_correct(correct), .o_last(last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // Reference field multiply: carry-less product reduced from the top by the full polynomial.
  function automatic logic [M-1:0] tmul(input logic [M-1:0] a, input logic [M-1:0] b,
                                        input logic [1:0] c);
    logic [2*M-1:0] p;
    logic [2*M-1:0] poly;
    int             d;
    case (c)
      2'b00:   begin poly = (2*M)'(11'h043); d = 6;  end
      2'b01:   begin poly = (2*M)'(11'h11D); d = 8;  end
      default: begin poly = (2*M)'(11'h409); d = 10; end
    endcase
    p = '0;
    for (int i = 0; i < int'(M); i++) if (b[i]) p = p ^ ((2*M)'(a) << i);
    for (int i = 2 * int'(M) - 1; i >= d; i--) if (p[i]) p = p ^ (poly << (i - d));
    return M'(p);
  endfunction

  function automatic logic [M-1:0] tpow(input int e, input logic [1:0] c);
    logic [M-1:0] x;
    x = M'(1);
    for (int j = 0; j < e; j++) x = tmul(x, M'(2), c);
    return x;
  endfunction

  // Product of (1 + alpha^e x) over the first n exponents: roots at positions e.
  function automatic logic [CW-1:0] lam_roots(input logic [1:0] c, input int n,
                                              input int e0, input int e1, input int e2, input int e3);
    logic [M-1:0]  lam [T_MAX+1];
    logic [M-1:0]  beta;
    logic [CW-1:0] r;
    int            ev [4];
    ev = '{e0, e1, e2, e3};
    for (int k = 0; k <= int'(T_MAX); k++) lam[k] = '0;
    lam[0] = M'(1);
    for (int j = 0; j < n; j++) begin
      beta = tpow(ev[j], c);
      for (int k = int'(T_MAX); k >= 1; k--) lam[k] = lam[k] ^ tmul(beta, lam[k-1], c);
    end
    r = '0;
    for (int k = 0; k <= int'(T_MAX); k++) r[k*M +: M] = lam[k];
    return r;
  endfunction

  function automatic logic [LW-1:0] locs(input int a, input int b, input int c, input int d);
    logic [LW-1:0] r;
    r = '0;
    r[0*M +: M] = M'(a);
    r[1*M +: M] = M'(b);
    r[2*M +: M] = M'(c);
    r[3*M +: M] = M'(d);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic start_job(input logic [1:0] c, input logic md, input logic [CW-1:0] sa,
                           input logic [CW-1:0] sb);
    code = c; mode = md; sigma_a = sa; sigma_b = sb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count further edges until o_valid is seen; a timeout is a failed check.
  task automatic wait_valid(input string nm, output int n);
    n = 0;
    while (!valid && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no o_valid after %0d cycles, expected a result", nm, n);
    end
  endtask

  task automatic check_result(input string nm, input logic [LW-1:0] eloc, input logic [2:0] enum_err,
                              input logic eok, input logic elast);
    chk({nm, "_valid"}, 64'(valid), 64'(1));
    chk({nm, "_loc"}, 64'(err_loc), 64'(eloc));
    chk({nm, "_num"}, 64'(num_err), 64'(enum_err));
    chk({nm, "_correct"}, 64'(correct), 64'(eok));
    chk({nm, "_last"}, 64'(last), 64'(elast));
  endtask

  typedef struct {
    string         name;
    logic [1:0]    code;
    logic          mode;
    logic [CW-1:0] sa;
    int            lat;
    logic [LW-1:0] loc;
    logic [2:0]    num;
    logic          ok;
  } vec_t;

  vec_t          vecs [10];
  logic [CW-1:0] sa, sb;
  int            n;
  int            spurious;

  initial begin
    rst_n = 1'b0; start = 1'b0; code = '0; mode = 1'b0; out_ready = 1'b1;
    sigma_a = '0; sigma_b = '0;

    sa = '0; sa[9:0] = 10'h3C1; sa[19:10] = 10'h040; sa[39:30] = 10'h155;
    vecs[0] = '{"c00_unity",    2'b00, 1'b0, CW'(1), 2, '0, 3'd0, 1'b1};
    vecs[1] = '{"c00_masked",   2'b00, 1'b0, sa, 2, '0, 3'd0, 1'b1};
    vecs[2] = '{"c00_root10",   2'b00, 1'b0, lam_roots(2'b00, 1, 10, 0, 0, 0), 9, locs(10, 0, 0, 0), 3'd1, 1'b1};
    vecs[3] = '{"c00_pos0",     2'b00, 1'b0, lam_roots(2'b00, 1, 0, 0, 0, 0), 10, '0, 3'd1, 1'b1};
    sa = '0; sa[19:10] = 10'h001;
    vecs[4] = '{"c00_no_c0",    2'b00, 1'b0, sa, 10, '0, 3'd0, 1'b0};
    vecs[5] = '{"c01_early",    2'b01, 1'b0, lam_roots(2'b01, 1, 250, 0, 0, 0), 3, locs(250, 0, 0, 0), 3'd1, 1'b1};
    vecs[6] = '{"c01_root5",    2'b01, 1'b0, lam_roots(2'b01, 1, 5, 0, 0, 0), 34, locs(5, 0, 0, 0), 3'd1, 1'b1};
    vecs[7] = '{"c10_four",     2'b10, 1'b0, lam_roots(2'b10, 4, 1000, 500, 100, 3), 130,
                locs(1000, 500, 100, 3), 3'd4, 1'b1};
    vecs[8] = '{"c10_mode_ign", 2'b10, 1'b1, lam_roots(2'b10, 1, 1022, 0, 0, 0), 3, locs(1022, 0, 0, 0), 3'd1, 1'b1};
    vecs[9] = '{"c11_illegal",  2'b11, 1'b1, CW'(1), 2, '0, 3'd0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_loc", 64'(err_loc), 64'(0));
    chk("rst_num", 64'(num_err), 64'(0));
    chk("rst_correct", 64'(correct), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      start_job(vecs[i].code, vecs[i].mode, vecs[i].sa, CW'(1));
      chk({vecs[i].name, "_busy"}, 64'(ready), 64'(0));
      wait_valid(vecs[i].name, n);
      chk({vecs[i].name, "_lat"}, 64'(n + 1), 64'(vecs[i].lat));
      check_result(vecs[i].name, vecs[i].loc, vecs[i].num, vecs[i].ok, 1'b1);
      @(posedge clk); #1;
      chk({vecs[i].name, "_drop"}, 64'(valid), 64'(0));
      chk({vecs[i].name, "_idle"}, 64'(ready), 64'(1));
    end

    // Two candidates: a single root, then an irreducible quadratic 1 + x + alpha^5 x^2.
    sa = lam_roots(2'b01, 1, 7, 0, 0, 0);
    sb = '0; sb[9:0] = 10'h001; sb[19:10] = 10'h001; sb[29:20] = 10'h020;
    start_job(2'b01, 1'b1, sa, sb);
    wait_valid("two_a", n);
    chk("two_a_lat", 64'(n + 1), 64'(33));
    check_result("two_a", locs(7, 0, 0, 0), 3'd1, 1'b1, 1'b0);
    wait_valid("two_b_pre", n);
    @(posedge clk); #1;
    chk("two_a_drop", 64'(valid), 64'(0));
    chk("two_a_busy", 64'(ready), 64'(0));
    wait_valid("two_b", n);
    chk("two_b_lat", 64'(n + 1), 64'(34));
    check_result("two_b", '0, 3'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("two_b_idle", 64'(ready), 64'(1));

    // Back-pressure: result held for 5 cycles while a stray start is ignored.
    out_ready = 1'b0;
    start_job(2'b00, 1'b0, lam_roots(2'b00, 1, 10, 0, 0, 0), CW'(1));
    wait_valid("hold", n);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        code = 2'b01; sigma_a = CW'(1); start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      check_result($sformatf("hold_c%0d", c), locs(10, 0, 0, 0), 3'd1, 1'b1, 1'b1);
      chk($sformatf("hold_c%0d_busy", c), 64'(ready), 64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_drop", 64'(valid), 64'(0));
    chk("hold_idle", 64'(ready), 64'(1));
    spurious = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (valid) spurious++;
    end
    chk("hold_ignored_start", 64'(spurious), 64'(0));

    // Reset in the middle of a long code-10 scan drops the job.
    start_job(2'b10, 1'b0, lam_roots(2'b10, 4, 1000, 500, 100, 3), CW'(1));
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(valid), 64'(0));
    chk("mid_rst_ready", 64'(ready), 64'(1));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    spurious = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (valid) spurious++;
    end
    chk("mid_rst_no_result", 64'(spurious), 64'(0));
    chk("mid_rst_ready_after", 64'(ready), 64'(1));
    chk("mid_rst_num", 64'(num_err), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
